// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART RX definitions: FSM state encoding, parity-type constants and
// the majority-vote helper used by the oversampling sampler.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_sampling.sv
// Mid-bit oversampler: two line samples just before the bit centre, then a
// 2-of-3 vote with the live line one oversample later.
module data_sampling
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      samp_bit
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] mid_s;
  logic                      samp0_r;
  logic                      samp1_r;
  logic                      samp_bit_r;

  assign mid_s = prescale >> 1'b1;

  // Capture the two pre-centre samples and the voted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp0_r    <= 1'b0;
      samp1_r    <= 1'b0;
      samp_bit_r <= 1'b0;
    end else begin
      if (edge_cnt == (mid_s - ONE)) samp0_r <= rx_in;
      if (edge_cnt == mid_s)         samp1_r <= rx_in;
      if (edge_cnt == (mid_s + ONE)) samp_bit_r <= majority3(samp0_r, samp1_r, rx_in);
    end
  end

  assign samp_bit = samp_bit_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, LSB-first shift register and the
// registered data_valid / par_err / stp_err pulses.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-2:0] bit_cnt,
  output logic                      edge_bit_en,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] TWO      = PRESCALE_WIDTH'(2);
  localparam logic [PRESCALE_WIDTH-2:0] BIT_LAST = (PRESCALE_WIDTH-1)'(DATA_WIDTH);

  rx_state_e             state_r;
  rx_state_e             next_state_s;
  logic                  samp_bit_s;
  logic                  last_edge_s;
  logic                  stop_edge_s;
  logic                  edge_bit_en_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  par_flag_r;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stp_err_r;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  data_sampling #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampling (
    .clk      (CLK),
    .rst_n    (RST),
    .rx_in    (RX_IN),
    .prescale (Prescale),
    .edge_cnt (edge_cnt),
    .samp_bit (samp_bit_s)
  );

  assign last_edge_s = (edge_cnt == (Prescale - ONE));
  // Stop is left half a bit early so an immediately following start edge is caught.
  assign stop_edge_s = (edge_cnt == ((Prescale >> 1'b1) + TWO));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= next_state_s;
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!RX_IN) next_state_s = ST_START;
        else        next_state_s = ST_IDLE;
      end
      ST_START: begin
        if (last_edge_s) next_state_s = samp_bit_s ? ST_IDLE : ST_DATA;
        else             next_state_s = ST_START;
      end
      ST_DATA: begin
        if (last_edge_s && (bit_cnt == BIT_LAST)) next_state_s = par_en_r ? ST_PARITY : ST_STOP;
        else                                      next_state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (last_edge_s) next_state_s = ST_STOP;
        else             next_state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (stop_edge_s) next_state_s = ST_IDLE;
        else             next_state_s = ST_STOP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Moore output: counter enabled whenever a frame is in progress.
  always_comb begin
    edge_bit_en_s = 1'b0;
    case (state_r)
      ST_IDLE: edge_bit_en_s = 1'b0;
      default: edge_bit_en_s = 1'b1;
    endcase
  end

  // Frame datapath: config latch, shift register, parity flag and result pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_r      <= '0;
      p_data_r     <= '0;
      par_en_r     <= 1'b0;
      par_typ_r    <= PAR_EVEN;
      par_flag_r   <= 1'b0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!RX_IN) begin
            par_en_r   <= PAR_EN;
            par_typ_r  <= PAR_TYP;
            par_flag_r <= 1'b0;
          end
        end
        ST_DATA: begin
          if (last_edge_s) shift_r <= {samp_bit_s, shift_r[DATA_WIDTH-1:1]};
        end
        ST_PARITY: begin
          if (last_edge_s) par_flag_r <= (samp_bit_s != expected_parity(shift_r, par_typ_r));
        end
        ST_STOP: begin
          if (stop_edge_s) begin
            stp_err_r <= ~samp_bit_s;
            par_err_r <= par_flag_r;
            if (samp_bit_s && !par_flag_r) begin
              data_valid_r <= 1'b1;
              p_data_r     <= shift_r;
            end
          end
        end
        default: begin
          shift_r <= shift_r;
        end
      endcase
    end
  end

  assign edge_bit_en = edge_bit_en_s;
  assign P_DATA      = p_data_r;
  assign data_valid  = data_valid_r;
  assign par_err     = par_err_r;
  assign stp_err     = stp_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames are built from the UART
// frame rules and outcomes predicted from data/parity/stop alone.
module tb_uart_rx_ctrl;

  localparam int PW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] edge_cnt;
  logic [PW-2:0] bit_cnt;
  logic          edge_bit_en;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int            n_cmp = 0;
  int            n_err = 0;
  int            dv_n  = 0;
  int            pe_n  = 0;
  int            se_n  = 0;
  logic [DW-1:0] dv_q[$];
  logic [DW-1:0] exp_pdata;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .RX_IN       (rx_in),
    .Prescale    (prescale),
    .PAR_EN      (par_en),
    .PAR_TYP     (par_typ),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .edge_bit_en (edge_bit_en),
    .P_DATA      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  // External edge/bit counter the controller expects to drive.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!edge_bit_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale - PW'(1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + (PW-1)'(1);
    end else begin
      edge_cnt <= edge_cnt + PW'(1);
    end
  end

  // Pulse monitor, sampled mid-cycle; counts high cycles of each pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_n <= dv_n + 1;
        dv_q.push_back(p_data);
      end
      if (par_err) pe_n <= pe_n + 1;
      if (stp_err) se_n <= se_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    tick(p);
  endtask

  // Serial frame: start, data LSB first, optional parity, stop, then idle gap.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic flip, input logic stopv, input int p,
                            input int gap, input logic wiggle);
    prescale = PW'(p);
    par_en   = pen;
    par_typ  = ptyp;
    drive_bit(1'b0, p);
    if (wiggle) begin
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) drive_bit(d[i], p);
    if (pen) drive_bit((^d) ^ ptyp ^ flip, p);
    drive_bit(stopv, p);
    rx_in = 1'b1;
    tick(gap);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic flip, input logic stopv,
                           input int p, input logic wiggle);
    int   dv0;
    int   pe0;
    int   se0;
    logic ep;
    logic es;
    logic ev;
    dv0 = dv_n;
    pe0 = pe_n;
    se0 = se_n;
    ep  = pen && flip;
    es  = !stopv;
    ev  = !ep && !es;
    send_frame(d, pen, ptyp, flip, stopv, p, 3 * p, wiggle);
    if (ev) exp_pdata = d;
    chk({tag, "_valid"}, 32'(dv_n - dv0), 32'(ev));
    chk({tag, "_par_err"}, 32'(pe_n - pe0), 32'(ep));
    chk({tag, "_stp_err"}, 32'(se_n - se0), 32'(es));
    chk({tag, "_pdata"}, 32'(p_data), 32'(exp_pdata));
    chk({tag, "_en_idle"}, 32'(edge_bit_en), 32'h0);
  endtask

  initial begin
    int            dv0;
    int            pe0;
    int            se0;
    int            q0;
    logic [DW-1:0] q_a;
    logic [DW-1:0] q_b;
    logic [7:0]    d;
    int            p;

    rst_n     = 1'b0;
    rx_in     = 1'b1;
    prescale  = PW'(8);
    par_en    = 1'b0;
    par_typ   = 1'b0;
    exp_pdata = '0;
    tick(3);
    chk("reset_en", 32'(edge_bit_en), 32'h0);
    chk("reset_pdata", 32'(p_data), 32'h0);
    chk("reset_pulses", 32'({data_valid, par_err, stp_err}), 32'h0);
    rst_n = 1'b1;
    tick(4);
    chk("post_reset_en", 32'(edge_bit_en), 32'h0);

    run_frame("p8_even_ok", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    run_frame("p8_even_bad", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b0);
    run_frame("p16_stop0", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0);
    run_frame("p16_odd_ok", 8'h5E, 1'b1, 1'b1, 1'b0, 1'b1, 16, 1'b0);

    // Two-cycle glitch: start is entered, then abandoned.
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    prescale = PW'(16);
    par_en   = 1'b0;
    rx_in    = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(3);
    chk("glitch_en_start", 32'(edge_bit_en), 32'h1);
    tick(40);
    chk("glitch_en_drop", 32'(edge_bit_en), 32'h0);
    chk("glitch_pulses", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0)), 32'h0);

    // Back-to-back frames with no idle gap.
    dv0 = dv_n;
    q0  = dv_q.size();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32, 0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32, 96, 1'b0);
    chk("b2b_count", 32'(dv_n - dv0), 32'h2);
    q_a = (dv_q.size() > q0)     ? dv_q[q0]     : 8'hxx;
    q_b = (dv_q.size() > q0 + 1) ? dv_q[q0 + 1] : 8'hxx;
    chk("b2b_first", 32'(q_a), 32'h00);
    chk("b2b_second", 32'(q_b), 32'hFF);
    exp_pdata = 8'hFF;
    chk("b2b_pdata", 32'(p_data), 32'(exp_pdata));

    // Reset in the middle of the 4th data bit.
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;
    d = 8'h5A;
    prescale = PW'(8);
    par_en   = 1'b1;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
    rx_in = d[3];
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'(edge_bit_en), 32'h0);
    chk("rst_mid_pdata", 32'(p_data), 32'h0);
    chk("rst_mid_pulses", 32'({data_valid, par_err, stp_err}), 32'h0);
    exp_pdata = '0;
    rx_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("rst_mid_no_pulse", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0)), 32'h0);
    run_frame("after_rst_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0);

    // Random frames with mid-frame config changes.
    for (int k = 0; k < 12; k++) begin
      p = 8 << $urandom_range(2, 0);
      run_frame($sformatf("rand%0d", k), 8'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0), p, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
